// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory-access stage.
// The flag indices follow the [0:3] N,Z,C,V ordering of the flags bus.
package cpu_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam int DEF_REG_IDX_W = 5;

    // Next value of the NZCV register when an instruction retires.
    function automatic logic [0:3] apply_flags(input logic [0:3] cur,
                                               input logic [0:3] alu_flags,
                                               input logic       en);
        logic [0:3] nxt;
        nxt = cur;
        if (en) begin
            nxt[FLAG_N] = alu_flags[FLAG_N];
            nxt[FLAG_Z] = alu_flags[FLAG_Z];
            nxt[FLAG_C] = alu_flags[FLAG_C];
            nxt[FLAG_V] = alu_flags[FLAG_V];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack handshake: IDLE/ACCESS FSM, held request fields and
// the optional ack-wait timeout (enabled by MEM_TIMEOUT_EN).
module dmem_handshake
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 64
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic              is_mem_i,
    input  logic              is_store_i,
    input  logic [0:63]       addr_i,
    input  logic [0:63]       wdata_i,
    input  logic              dmem_ack_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [0:ADDR_W-1] dmem_addr_o,
    output logic [0:63]       dmem_wdata_o,
    output logic              busy_o,
    output logic              launch_o,
    output logic              misalign_o,
    output logic              done_o,
    output logic              timeout_o
);

    mem_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [0:ADDR_W-1] addr_q, addr_d;
    logic [0:63]       wdata_q, wdata_d;
    logic              mem_op;
    logic              aligned;

    assign mem_op     = (state_q == IDLE) && in_valid_i && is_mem_i;
    assign aligned    = (addr_i[61:63] == 3'b000);
    assign launch_o   = mem_op && aligned;
    assign misalign_o = mem_op && !aligned;
    assign done_o     = (state_q == ACCESS) && dmem_ack_i;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Counts completed wait cycles; gives up on the TIMEOUT-th unacknowledged cycle.
    assign wait_cnt_d = (state_q == ACCESS) ? wait_cnt_q + 8'd1 : 8'd0;
    assign timeout_o  = (state_q == ACCESS) && !dmem_ack_i
                        && (wait_cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (launch_o) begin
                    state_d = ACCESS;
                    we_d    = is_store_i;
                    addr_d  = addr_i[64-ADDR_W +: ADDR_W];
                    wdata_d = wdata_i;
                end
            end
            ACCESS: begin
                if (done_o || timeout_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The request is the ACCESS state itself, so reset withdraws it at once.
    assign busy_o       = (state_q == ACCESS);
    assign dmem_req_o   = (state_q == ACCESS);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: one 64-bit load/store per instruction, NZCV register, branch
// resolution and writeback register. Define MEM_TIMEOUT_EN for the ack timeout.
module memory_access_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int REG_IDX_W = DEF_REG_IDX_W
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [0:63]          alu_result,
    input  logic [0:63]          operand_b,
    input  logic                 regwrite,
    input  logic [REG_IDX_W-1:0] write_addr,
    input  logic                 memwrite,
    input  logic                 memtoreg,
    input  logic                 branch,
    input  logic                 setflags,
    input  logic [0:3]           flags,
    output logic                 mem_stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [0:ADDR_W-1]    dmem_addr,
    output logic [0:63]          dmem_wdata,
    input  logic [0:63]          dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 wb_valid,
    output logic                 wb_regwrite,
    output logic [REG_IDX_W-1:0] wb_write_addr,
    output logic [0:63]          wb_data,
    output logic                 branch_taken,
    output logic [0:3]           nzcv,
    output logic                 mem_fault
);

    logic busy, launch, misalign, done, timeout, retire_direct;

    dmem_handshake #(
        .ADDR_W(ADDR_W)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT(TIMEOUT)
`endif
    ) u_handshake (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .is_mem_i    (memwrite | memtoreg),
        .is_store_i  (memwrite),
        .addr_i      (alu_result),
        .wdata_i     (operand_b),
        .dmem_ack_i  (dmem_ack),
        .dmem_req_o  (dmem_req),
        .dmem_we_o   (dmem_we),
        .dmem_addr_o (dmem_addr),
        .dmem_wdata_o(dmem_wdata),
        .busy_o      (busy),
        .launch_o    (launch),
        .misalign_o  (misalign),
        .done_o      (done),
        .timeout_o   (timeout)
    );

    // Fields of the instruction parked in the stage while its access is outstanding.
    logic                 pend_regwrite_q, pend_regwrite_d;
    logic [REG_IDX_W-1:0] pend_addr_q, pend_addr_d;
    logic                 pend_load_q, pend_load_d;
    logic [0:63]          pend_alu_q, pend_alu_d;
    logic                 pend_setflags_q, pend_setflags_d;
    logic [0:3]           pend_flags_q, pend_flags_d;
    logic                 pend_branch_q, pend_branch_d;

    logic                 wb_valid_q, wb_valid_d;
    logic                 wb_regwrite_q, wb_regwrite_d;
    logic [REG_IDX_W-1:0] wb_addr_q, wb_addr_d;
    logic [0:63]          wb_data_q, wb_data_d;
    logic [0:3]           nzcv_q, nzcv_d;
    logic                 branch_taken_q, branch_taken_d;
    logic                 mem_fault_q, mem_fault_d;

    // Non-memory and misaligned instructions leave on the very next edge.
    assign retire_direct = !busy && in_valid && !launch;

    always_comb begin
        pend_regwrite_d = pend_regwrite_q;
        pend_addr_d     = pend_addr_q;
        pend_load_d     = pend_load_q;
        pend_alu_d      = pend_alu_q;
        pend_setflags_d = pend_setflags_q;
        pend_flags_d    = pend_flags_q;
        pend_branch_d   = pend_branch_q;
        wb_valid_d      = 1'b0;
        wb_regwrite_d   = 1'b0;
        wb_addr_d       = wb_addr_q;
        wb_data_d       = wb_data_q;
        nzcv_d          = nzcv_q;
        branch_taken_d  = 1'b0;
        mem_fault_d     = 1'b0;

        if (launch) begin
            // A store never writes the register file, even with memtoreg set.
            pend_regwrite_d = regwrite & ~memwrite;
            pend_addr_d     = write_addr;
            pend_load_d     = memtoreg & ~memwrite;
            pend_alu_d      = alu_result;
            pend_setflags_d = setflags;
            pend_flags_d    = flags;
            pend_branch_d   = branch;
        end

        if (retire_direct) begin
            wb_valid_d     = 1'b1;
            wb_regwrite_d  = regwrite & ~misalign;
            wb_addr_d      = write_addr;
            wb_data_d      = alu_result;
            nzcv_d         = apply_flags(nzcv_q, flags, setflags);
            branch_taken_d = branch & nzcv_q[FLAG_Z];
            mem_fault_d    = misalign;
        end else if (done || timeout) begin
            wb_valid_d     = 1'b1;
            wb_regwrite_d  = pend_regwrite_q & ~timeout;
            wb_addr_d      = pend_addr_q;
            wb_data_d      = (pend_load_q && done) ? dmem_rdata : pend_alu_q;
            nzcv_d         = apply_flags(nzcv_q, pend_flags_q, pend_setflags_q);
            branch_taken_d = pend_branch_q & nzcv_q[FLAG_Z];
            mem_fault_d    = timeout;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_regwrite_q <= 1'b0;
            pend_addr_q     <= '0;
            pend_load_q     <= 1'b0;
            pend_alu_q      <= '0;
            pend_setflags_q <= 1'b0;
            pend_flags_q    <= '0;
            pend_branch_q   <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_regwrite_q   <= 1'b0;
            wb_addr_q       <= '0;
            wb_data_q       <= '0;
            nzcv_q          <= '0;
            branch_taken_q  <= 1'b0;
            mem_fault_q     <= 1'b0;
        end else begin
            pend_regwrite_q <= pend_regwrite_d;
            pend_addr_q     <= pend_addr_d;
            pend_load_q     <= pend_load_d;
            pend_alu_q      <= pend_alu_d;
            pend_setflags_q <= pend_setflags_d;
            pend_flags_q    <= pend_flags_d;
            pend_branch_q   <= pend_branch_d;
            wb_valid_q      <= wb_valid_d;
            wb_regwrite_q   <= wb_regwrite_d;
            wb_addr_q       <= wb_addr_d;
            wb_data_q       <= wb_data_d;
            nzcv_q          <= nzcv_d;
            branch_taken_q  <= branch_taken_d;
            mem_fault_q     <= mem_fault_d;
        end
    end

    assign mem_stall     = busy;
    assign wb_valid      = wb_valid_q;
    assign wb_regwrite   = wb_regwrite_q;
    assign wb_write_addr = wb_addr_q;
    assign wb_data       = wb_data_q;
    assign nzcv          = nzcv_q;
    assign branch_taken  = branch_taken_q;
    assign mem_fault     = mem_fault_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: vector table for single-cycle instructions,
// directed load/store/reset sequences, then randomized traffic vs. a reference model.
module tb_memory_access_stage;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, regwrite, memwrite, memtoreg, branch, setflags, dmem_ack;
    logic [63:0]   alu_result, operand_b, dmem_rdata;
    logic [RW-1:0] write_addr;
    logic [0:3]    flags;
    logic          mem_stall, dmem_req, dmem_we, wb_valid, wb_regwrite, branch_taken, mem_fault;
    logic [63:0]   dmem_addr, dmem_wdata, wb_data;
    logic [RW-1:0] wb_write_addr;
    logic [0:3]    nzcv;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .alu_result   (alu_result),
        .operand_b    (operand_b),
        .regwrite     (regwrite),
        .write_addr   (write_addr),
        .memwrite     (memwrite),
        .memtoreg     (memtoreg),
        .branch       (branch),
        .setflags     (setflags),
        .flags        (flags),
        .mem_stall    (mem_stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .wb_valid     (wb_valid),
        .wb_regwrite  (wb_regwrite),
        .wb_write_addr(wb_write_addr),
        .wb_data      (wb_data),
        .branch_taken (branch_taken),
        .nzcv         (nzcv),
        .mem_fault    (mem_fault)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; regwrite = 0; write_addr = '0; alu_result = '0; operand_b = '0;
        memwrite = 0; memtoreg = 0; branch = 0; setflags = 0; flags = 4'b0000;
    endtask

    task automatic drive(input logic iv, input logic rw, input logic [RW-1:0] wa,
                         input logic [63:0] alu, input logic [63:0] opb, input logic mw,
                         input logic mr, input logic br, input logic sf, input logic [0:3] fl);
        in_valid = iv; regwrite = rw; write_addr = wa; alu_result = alu; operand_b = opb;
        memwrite = mw; memtoreg = mr; branch = br; setflags = sf; flags = fl;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dmem_req"}, 64'(dmem_req), 64'd0);
        check({tag, " dmem_we"}, 64'(dmem_we), 64'd0);
        check({tag, " dmem_addr"}, dmem_addr, 64'd0);
        check({tag, " dmem_wdata"}, dmem_wdata, 64'd0);
        check({tag, " mem_stall"}, 64'(mem_stall), 64'd0);
        check({tag, " wb_valid"}, 64'(wb_valid), 64'd0);
        check({tag, " wb_regwrite"}, 64'(wb_regwrite), 64'd0);
        check({tag, " wb_write_addr"}, 64'(wb_write_addr), 64'd0);
        check({tag, " wb_data"}, wb_data, 64'd0);
        check({tag, " nzcv"}, 64'(nzcv), 64'd0);
        check({tag, " branch_taken"}, 64'(branch_taken), 64'd0);
        check({tag, " mem_fault"}, 64'(mem_fault), 64'd0);
    endtask

    typedef struct {
        logic          iv, rw;
        logic [RW-1:0] wa;
        logic [63:0]   alu;
        logic          mw, mr, br, sf;
        logic [0:3]    fl;
        logic          e_valid, e_rw;
        logic [0:3]    e_nzcv;
        logic          e_bt, e_fault;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:3]    nzcv_m;
        logic [63:0]   i_alu, i_opb, i_rdata;
        logic [RW-1:0] i_wa;
        logic          i_rw, i_mw, i_mr, i_br, i_sf, mis, is_mem;
        logic [0:3]    i_fl;
        int            kind, waits;

        //                iv rw wa     alu                    mw mr br sf fl        ev erw nzcv     bt flt
        vecs[0]  = '{1'b1, 1'b1, 5'd3,  64'h2A,               1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 5'd4,  64'h99,               1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5'd7,  64'h5,                1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5'd0,  64'h40,               1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 5'd0,  64'h44,               1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5'd0,  64'h48,               1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 5'd9,  64'h103,              1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 5'd2,  64'hC,                1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 5'd12, 64'h201,              1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 5'd1,  64'h0,                1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  64'h0,                1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0};

        // Reset state
        rst = 1'b0; dmem_ack = 0; dmem_rdata = '0; set_idle();
        #1;
        check_all_zero("reset");
        step(); step();
        #2 rst = 1'b1;
        step();
        check_all_zero("post-reset idle");

        // Single-cycle vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].iv, vecs[i].rw, vecs[i].wa, vecs[i].alu, 64'h0, vecs[i].mw,
                  vecs[i].mr, vecs[i].br, vecs[i].sf, vecs[i].fl);
            step();
            $display("[TB] vec %0d alu=%0h valid=%0b", i, vecs[i].alu, vecs[i].iv);
            check($sformatf("vec%0d wb_valid", i), 64'(wb_valid), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d wb_regwrite", i), 64'(wb_regwrite), 64'(vecs[i].e_rw));
            check($sformatf("vec%0d nzcv", i), 64'(nzcv), 64'(vecs[i].e_nzcv));
            check($sformatf("vec%0d branch_taken", i), 64'(branch_taken), 64'(vecs[i].e_bt));
            check($sformatf("vec%0d mem_fault", i), 64'(mem_fault), 64'(vecs[i].e_fault));
            check($sformatf("vec%0d mem_stall", i), 64'(mem_stall), 64'd0);
            check($sformatf("vec%0d dmem_req", i), 64'(dmem_req), 64'd0);
            if (vecs[i].e_valid && !vecs[i].e_fault) begin
                check($sformatf("vec%0d wb_data", i), wb_data, vecs[i].alu);
                check($sformatf("vec%0d wb_write_addr", i), 64'(wb_write_addr), 64'(vecs[i].wa));
            end
        end
        set_idle();

        // Load at 0x100, three wait cycles, then ack; next ALU op held behind it
        $display("[TB] seq load 0x100 with 3 waits");
        drive(1, 1, 5'd6, 64'h100, 64'h0, 0, 1, 0, 0, 4'b0000);
        step();
        drive(1, 1, 5'd4, 64'h77, 64'h0, 0, 0, 0, 0, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin dmem_ack = 1; dmem_rdata = 64'hDEADBEEF; end
            check($sformatf("load c%0d dmem_req", c), 64'(dmem_req), 64'd1);
            check($sformatf("load c%0d mem_stall", c), 64'(mem_stall), 64'd1);
            check($sformatf("load c%0d dmem_we", c), 64'(dmem_we), 64'd0);
            check($sformatf("load c%0d dmem_addr", c), dmem_addr, 64'h100);
            check($sformatf("load c%0d wb_valid", c), 64'(wb_valid), 64'd0);
            step();
        end
        dmem_ack = 0;
        check("load dmem_req dropped", 64'(dmem_req), 64'd0);
        check("load mem_stall dropped", 64'(mem_stall), 64'd0);
        check("load wb_valid", 64'(wb_valid), 64'd1);
        check("load wb_data", wb_data, 64'hDEADBEEF);
        check("load wb_regwrite", 64'(wb_regwrite), 64'd1);
        check("load wb_write_addr", 64'(wb_write_addr), 64'd6);
        step();
        check("held alu wb_data", wb_data, 64'h77);
        check("held alu wb_write_addr", 64'(wb_write_addr), 64'd4);
        set_idle();

        // Store at 0x08, acked in its first request cycle
        $display("[TB] seq store 0x08");
        drive(1, 0, 5'd2, 64'h08, 64'h55, 1, 0, 0, 0, 4'b0000);
        step();
        check("store dmem_req", 64'(dmem_req), 64'd1);
        check("store dmem_we", 64'(dmem_we), 64'd1);
        check("store dmem_wdata", dmem_wdata, 64'h55);
        check("store dmem_addr", dmem_addr, 64'h08);
        set_idle();
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        check("store wb_valid", 64'(wb_valid), 64'd1);
        check("store wb_regwrite", 64'(wb_regwrite), 64'd0);
        check("store wb_data", wb_data, 64'h08);

        // memwrite and memtoreg together behave as a store
        $display("[TB] seq store+load flags at 0x10");
        drive(1, 0, 5'd5, 64'h10, 64'hAB, 1, 1, 0, 0, 4'b0000);
        step();
        check("both dmem_we", 64'(dmem_we), 64'd1);
        check("both dmem_wdata", dmem_wdata, 64'hAB);
        set_idle();
        dmem_ack = 1; dmem_rdata = 64'h1234;
        step();
        dmem_ack = 0;
        check("both wb_data", wb_data, 64'h10);

        // Stray ack while idle
        $display("[TB] seq ack in idle");
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        check("idle-ack dmem_req", 64'(dmem_req), 64'd0);
        check("idle-ack wb_valid", 64'(wb_valid), 64'd0);
        check("idle-ack mem_stall", 64'(mem_stall), 64'd0);

        // Reset asserted in the middle of an access, late ack after release
        $display("[TB] seq reset mid-access");
        drive(1, 1, 5'd8, 64'h200, 64'h0, 0, 1, 0, 0, 4'b0000);
        step();
        check("pre-reset dmem_req", 64'(dmem_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("mid-access reset");
        set_idle();
        @(posedge clk);
        #3 rst = 1'b1;
        step();
        dmem_ack = 1; dmem_rdata = 64'hCAFE;
        step();
        dmem_ack = 0;
        check("late-ack dmem_req", 64'(dmem_req), 64'd0);
        check("late-ack wb_valid", 64'(wb_valid), 64'd0);
        check("late-ack mem_stall", 64'(mem_stall), 64'd0);
        check("late-ack wb_data", wb_data, 64'd0);

        // Randomized traffic against a transaction-level model
        nzcv_m = 4'b0000;
        for (int t = 0; t < 60; t++) begin
            kind  = $urandom_range(0, 3);
            i_rw  = 1'($urandom_range(0, 1));
            i_wa  = RW'($urandom);
            i_alu = {$urandom, $urandom};
            i_opb = {$urandom, $urandom};
            i_br  = 1'($urandom_range(0, 1));
            i_sf  = 1'($urandom_range(0, 1));
            i_fl  = 4'($urandom);
            i_mw  = 0; i_mr = 0;
            case (kind)
                1: begin i_mr = 1; i_alu = i_alu & ~64'h7; end
                2: begin i_mw = 1; i_mr = 1'($urandom_range(0, 1)); i_rw = 0; i_alu = i_alu & ~64'h7; end
                3: begin
                    i_mw  = 1'($urandom_range(0, 1));
                    i_mr  = i_mw ? 1'($urandom_range(0, 1)) : 1'b1;
                    i_alu = (i_alu & ~64'h7) | 64'($urandom_range(1, 7));
                end
                default: ;
            endcase
            is_mem  = i_mw || i_mr;
            mis     = is_mem && ((i_alu % 8) != 0);
            i_rdata = {$urandom, $urandom};
            $display("[TB] txn %0d kind=%0d alu=%0h", t, kind, i_alu);

            drive(1, i_rw, i_wa, i_alu, i_opb, i_mw, i_mr, i_br, i_sf, i_fl);
            step();
            if (is_mem && !mis) begin
                waits = $urandom_range(0, 3);
                for (int w = 0; w <= waits; w++) begin
                    drive(1, 1'($urandom), RW'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                          1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 4'($urandom));
                    if (w == waits) begin dmem_ack = 1; dmem_rdata = i_rdata; end
                    check($sformatf("t%0d dmem_req", t), 64'(dmem_req), 64'd1);
                    check($sformatf("t%0d mem_stall", t), 64'(mem_stall), 64'd1);
                    check($sformatf("t%0d dmem_we", t), 64'(dmem_we), 64'(i_mw));
                    check($sformatf("t%0d dmem_addr", t), dmem_addr, i_alu);
                    if (i_mw) check($sformatf("t%0d dmem_wdata", t), dmem_wdata, i_opb);
                    check($sformatf("t%0d nzcv held", t), 64'(nzcv), 64'(nzcv_m));
                    check($sformatf("t%0d wb_valid busy", t), 64'(wb_valid), 64'd0);
                    step();
                    dmem_ack = 0;
                end
            end
            set_idle();
            check($sformatf("t%0d wb_valid", t), 64'(wb_valid), 64'd1);
            check($sformatf("t%0d wb_regwrite", t), 64'(wb_regwrite), 64'(i_rw && !mis && !i_mw));
            check($sformatf("t%0d mem_fault", t), 64'(mem_fault), 64'(mis));
            check($sformatf("t%0d branch_taken", t), 64'(branch_taken), 64'(i_br && nzcv_m[1]));
            check($sformatf("t%0d mem_stall", t), 64'(mem_stall), 64'd0);
            check($sformatf("t%0d dmem_req", t), 64'(dmem_req), 64'd0);
            if (!mis) begin
                check($sformatf("t%0d wb_data", t), wb_data, (i_mr && !i_mw) ? i_rdata : i_alu);
                check($sformatf("t%0d wb_write_addr", t), 64'(wb_write_addr), 64'(i_wa));
            end
            if (i_sf) nzcv_m = i_fl;
            check($sformatf("t%0d nzcv", t), 64'(nzcv), 64'(nzcv_m));
            if ($urandom_range(0, 3) == 0) begin
                step();
                check($sformatf("t%0d bubble wb_valid", t), 64'(wb_valid), 64'd0);
                check($sformatf("t%0d bubble branch_taken", t), 64'(branch_taken), 64'd0);
                check($sformatf("t%0d bubble mem_fault", t), 64'(mem_fault), 64'd0);
            end
        end

`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            $display("[TB] seq timeout");
            drive(1, 1, 5'd3, 64'h300, 64'h0, 0, 1, 0, 0, 4'b0000);
            step();
            set_idle();
            n = 0;
            while (dmem_req && n < 300) begin
                n++;
                step();
            end
            check("timeout request cycles", 64'(n), 64'd255);
            check("timeout mem_fault", 64'(mem_fault), 64'd1);
            check("timeout wb_valid", 64'(wb_valid), 64'd1);
            check("timeout wb_regwrite", 64'(wb_regwrite), 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
